ibex_load_store_unit: RTL

IBEX_LOAD_STORE_UNIT -- requirements
Module: ibex_load_store_unit

---
 rtl/ibex_load_store_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ibex_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ibex_load_store_unit
//  Purpose  : Load/store unit between the ID/EX stage and the data bus.
//             It splits misaligned accesses into two word-aligned bus beats,
//             generates byte enables and rotated store data, and realigns and
//             extends load data.
//  Ports    : clk_i, rst_ni               - clock, async active-low reset
//             data_*_ex_i, adder_result_ex_i - request from ID (held until
//                                          data_valid_o)
//             addr_incr_req_o, addr_last_o - ask ID for addr_last_o + 4
//             data_valid_o, data_rdata_ex_o, load_err_o, store_err_o, busy_o
//             data_req_o/gnt_i/rvalid_i/err_i/addr_o/we_o/be_o/wdata_o/rdata_i
//                                        - data bus
//  Revision : 1.0 - initial release
// ============================================================================
module ibex_load_store_unit (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        data_req_ex_i,
    input  logic        data_we_ex_i,
    input  logic [1:0]  data_type_ex_i,
    input  logic        data_sign_ext_ex_i,
    input  logic [31:0] data_wdata_ex_i,
    input  logic [31:0] adder_result_ex_i,

    output logic        addr_incr_req_o,
    output logic [31:0] addr_last_o,
    output logic        data_valid_o,
    output logic [31:0] data_rdata_ex_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic        busy_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        WAIT_GNT_MIS    = 3'd1,
        WAIT_RVALID_MIS = 3'd2,
        WAIT_GNT        = 3'd3,
        WAIT_RVALID     = 3'd4
    } ls_fsm_e;

    ls_fsm_e     ls_fsm_q;
    logic [31:0] addr_last_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        split_q;     // set while the second beat of a split access is in flight

    logic [1:0]  offset;
    logic        misaligned;
    logic        second_beat;
    logic [3:0]  be_first;
    logic [3:0]  be_second;
    logic [15:0] half_data;
    logic [7:0]  byte_data;

    // Before acceptance the offset comes straight from the ALU; afterwards
    // from the captured address, since ID replaces the ALU result with +4.
    assign offset      = (ls_fsm_q == IDLE) ? adder_result_ex_i[1:0] : addr_last_q[1:0];
    assign misaligned  = ((data_type_ex_i == 2'b00) && (offset != 2'b00)) ||
                         ((data_type_ex_i == 2'b01) && (offset == 2'b11));
    assign second_beat = ((ls_fsm_q == WAIT_RVALID_MIS) && data_rvalid_i) ||
                         ((ls_fsm_q == WAIT_GNT) && split_q);

    always_comb begin
        be_first  = 4'b0001 << offset;
        be_second = 4'b0000;
        case (data_type_ex_i)
            2'b00: begin
                be_first = 4'b1111 << offset;
                case (offset)
                    2'd1:    be_second = 4'b0001;
                    2'd2:    be_second = 4'b0011;
                    2'd3:    be_second = 4'b0111;
                    default: be_second = 4'b0000;
                endcase
            end
            2'b01: begin
                be_first  = 4'b0011 << offset;
                be_second = 4'b0001;
            end
            default: ;
        endcase
    end

    // Rotating by the byte offset puts each store byte on its lane in both beats.
    always_comb begin
        case (offset)
            2'd1:    data_wdata_o = {data_wdata_ex_i[23:0], data_wdata_ex_i[31:24]};
            2'd2:    data_wdata_o = {data_wdata_ex_i[15:0], data_wdata_ex_i[31:16]};
            2'd3:    data_wdata_o = {data_wdata_ex_i[7:0],  data_wdata_ex_i[31:8]};
            default: data_wdata_o = data_wdata_ex_i;
        endcase
    end

    assign data_req_o      = ((ls_fsm_q == IDLE) && data_req_ex_i) ||
                             (ls_fsm_q == WAIT_GNT_MIS) || (ls_fsm_q == WAIT_GNT) ||
                             ((ls_fsm_q == WAIT_RVALID_MIS) && data_rvalid_i);
    assign data_addr_o     = ((ls_fsm_q == IDLE) || second_beat) ?
                             {adder_result_ex_i[31:2], 2'b00} : {addr_last_q[31:2], 2'b00};
    assign data_be_o       = second_beat ? be_second : be_first;
    assign data_we_o       = data_we_ex_i;
    assign addr_incr_req_o = (ls_fsm_q == WAIT_RVALID_MIS) || ((ls_fsm_q == WAIT_GNT) && split_q);
    assign addr_last_o     = addr_last_q;
    assign busy_o          = (ls_fsm_q != IDLE);
    assign data_valid_o    = (ls_fsm_q == WAIT_RVALID) && data_rvalid_i;
    assign load_err_o      = data_valid_o && !data_we_ex_i && (err_q || data_err_i);
    assign store_err_o     = data_valid_o &&  data_we_ex_i && (err_q || data_err_i);

    // Load realignment: the low part of a split access sits in rdata_q.
    always_comb begin
        case (offset)
            2'd1:    half_data = data_rdata_i[23:8];
            2'd2:    half_data = data_rdata_i[31:16];
            2'd3:    half_data = {data_rdata_i[7:0], rdata_q[31:24]};
            default: half_data = data_rdata_i[15:0];
        endcase
        case (offset)
            2'd1:    byte_data = data_rdata_i[15:8];
            2'd2:    byte_data = data_rdata_i[23:16];
            2'd3:    byte_data = data_rdata_i[31:24];
            default: byte_data = data_rdata_i[7:0];
        endcase
        case (data_type_ex_i)
            2'b00: begin
                case (offset)
                    2'd1:    data_rdata_ex_o = {data_rdata_i[7:0],  rdata_q[31:8]};
                    2'd2:    data_rdata_ex_o = {data_rdata_i[15:0], rdata_q[31:16]};
                    2'd3:    data_rdata_ex_o = {data_rdata_i[23:0], rdata_q[31:24]};
                    default: data_rdata_ex_o = data_rdata_i;
                endcase
            end
            2'b01:   data_rdata_ex_o = {{16{data_sign_ext_ex_i & half_data[15]}}, half_data};
            default: data_rdata_ex_o = {{24{data_sign_ext_ex_i & byte_data[7]}}, byte_data};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ls_fsm_q    <= IDLE;
            addr_last_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            split_q     <= 1'b0;
        end else begin
            case (ls_fsm_q)
                IDLE: begin
                    err_q   <= 1'b0;
                    split_q <= 1'b0;
                    if (data_req_ex_i) begin
                        addr_last_q <= adder_result_ex_i;
                        if (data_gnt_i) ls_fsm_q <= misaligned ? WAIT_RVALID_MIS : WAIT_RVALID;
                        else            ls_fsm_q <= misaligned ? WAIT_GNT_MIS    : WAIT_GNT;
                    end
                end
                WAIT_GNT_MIS: begin
                    if (data_gnt_i) ls_fsm_q <= WAIT_RVALID_MIS;
                end
                WAIT_RVALID_MIS: begin
                    if (data_rvalid_i) begin
                        rdata_q  <= data_rdata_i;
                        err_q    <= data_err_i;
                        split_q  <= 1'b1;
                        ls_fsm_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (data_gnt_i) ls_fsm_q <= WAIT_RVALID;
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        err_q    <= 1'b0;
                        split_q  <= 1'b0;
                        ls_fsm_q <= IDLE;
                    end
                end
                default: ls_fsm_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
